// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// A round-robin arbiter picks a winner in IDLE, latches its operands and
// holds them on the ALU port, captures the ALU result one cycle later and
// presents it on the winner's response channel until it is taken.
// Optional build macro: ALU_ARB_FIXED_PRIO_EN -- req0 always wins simultaneous
// requests and the round-robin pointer is frozen (req1 may starve).
module alu_arbiter #(
  parameter int WORD_SIZE  = 8,
  parameter int MODE_WIDTH = 4,
  parameter int FLAG_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [WORD_SIZE-1:0]  req0_a,
  input  logic [WORD_SIZE-1:0]  req0_b,
  input  logic [MODE_WIDTH-1:0] req0_mode,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [WORD_SIZE-1:0]  req1_a,
  input  logic [WORD_SIZE-1:0]  req1_b,
  input  logic [MODE_WIDTH-1:0] req1_mode,
  output logic                  resp0_valid,
  input  logic                  resp0_ready,
  output logic [WORD_SIZE-1:0]  resp0_result,
  output logic [FLAG_WIDTH-1:0] resp0_flags,
  output logic                  resp1_valid,
  input  logic                  resp1_ready,
  output logic [WORD_SIZE-1:0]  resp1_result,
  output logic [FLAG_WIDTH-1:0] resp1_flags,
  output logic [WORD_SIZE-1:0]  alu_input_A,
  output logic [WORD_SIZE-1:0]  alu_input_B,
  output logic [MODE_WIDTH-1:0] alu_mode,
  input  logic [WORD_SIZE-1:0]  alu_output_C,
  input  logic [FLAG_WIDTH-1:0] alu_flags,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t                state_r;
  state_t                next_state_s;
  logic                  last_grant_r;
  logic                  owner_r;
  logic [WORD_SIZE-1:0]  a_r;
  logic [WORD_SIZE-1:0]  b_r;
  logic [MODE_WIDTH-1:0] mode_r;
  logic [WORD_SIZE-1:0]  result0_r;
  logic [FLAG_WIDTH-1:0] flags0_r;
  logic [WORD_SIZE-1:0]  result1_r;
  logic [FLAG_WIDTH-1:0] flags1_r;
  logic                  grant0_s;
  logic                  grant1_s;
  logic                  resp_take_s;

  // Arbitration and next-state decode; grants only exist in IDLE.
  always_comb begin
    next_state_s = state_r;
    grant0_s     = 1'b0;
    grant1_s     = 1'b0;
    resp_take_s  = 1'b0;
    case (state_r)
      IDLE: begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        grant0_s = req0_valid;
`else
        // last_grant_r == 1 means req1 went last, so req0 has the turn.
        grant0_s = req0_valid && (!req1_valid || last_grant_r);
`endif
        grant1_s = req1_valid && !grant0_s;
        if (grant0_s || grant1_s) begin
          next_state_s = ISSUE;
        end else begin
          next_state_s = IDLE;
        end
      end
      ISSUE: begin
        next_state_s = RESPOND;
      end
      RESPOND: begin
        // Only the owner's ready counts; the other channel's ready is ignored.
        resp_take_s = owner_r ? resp1_ready : resp0_ready;
        if (resp_take_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = RESPOND;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Operand latch on accept, result capture at the end of ISSUE, pointer update on hand-off.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_r <= 1'b1;
      owner_r      <= 1'b0;
      a_r          <= {WORD_SIZE{1'b0}};
      b_r          <= {WORD_SIZE{1'b0}};
      mode_r       <= {MODE_WIDTH{1'b0}};
      result0_r    <= {WORD_SIZE{1'b0}};
      flags0_r     <= {FLAG_WIDTH{1'b0}};
      result1_r    <= {WORD_SIZE{1'b0}};
      flags1_r     <= {FLAG_WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (grant0_s) begin
            a_r     <= req0_a;
            b_r     <= req0_b;
            mode_r  <= req0_mode;
            owner_r <= 1'b0;
          end else if (grant1_s) begin
            a_r     <= req1_a;
            b_r     <= req1_b;
            mode_r  <= req1_mode;
            owner_r <= 1'b1;
          end
        end
        ISSUE: begin
          // Each requester keeps its own copy so its channel holds its last result.
          if (owner_r) begin
            result1_r <= alu_output_C;
            flags1_r  <= alu_flags;
          end else begin
            result0_r <= alu_output_C;
            flags0_r  <= alu_flags;
          end
        end
        RESPOND: begin
`ifndef ALU_ARB_FIXED_PRIO_EN
          if (resp_take_s) begin
            last_grant_r <= owner_r;
          end
`endif
        end
        default: begin
          owner_r <= 1'b0;
        end
      endcase
    end
  end

  // Ready is a same-cycle answer to valid; it is forced low while reset is held.
  assign req0_ready   = grant0_s && reset_n;
  assign req1_ready   = grant1_s && reset_n;

  assign resp0_valid  = (state_r == RESPOND) && !owner_r;
  assign resp1_valid  = (state_r == RESPOND) && owner_r;
  assign resp0_result = result0_r;
  assign resp0_flags  = flags0_r;
  assign resp1_result = result1_r;
  assign resp1_flags  = flags1_r;

  // The ALU sees the latched operands in every state, so it never toggles between ops.
  assign alu_input_A  = a_r;
  assign alu_input_B  = b_r;
  assign alu_mode     = mode_r;

  assign busy         = (state_r != IDLE);

endmodule
